// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, FSM state encodings and gap timing for the serial master
package bus_pkg;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int BLEN_W     = 12;
    localparam int GAP_CYCLES = 8;
    localparam int CNT_W      = $clog2(ADDR_W);
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_REQ    = 3'd1;
    localparam state_t S_SHIFT  = 3'd2;
    localparam state_t S_DSHIFT = 3'd3;
    localparam state_t S_GAP    = 3'd4;
    localparam state_t S_DONE   = 3'd5;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shift register, LSB first, zeros shifted in from the top
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] pdata_i,
    output logic         sout_o
);
    logic [W-1:0] sr_q;
    // load wins over shift so a fresh word is never skewed by a same-cycle shift
    always_ff @(posedge clk or posedge reset)
        if (reset)        sr_q <= '0;
        else if (load_i)  sr_q <= pdata_i;
        else if (shift_i) sr_q <= {1'b0, sr_q[W-1:1]};
    assign sout_o = sr_q[0];
endmodule

// File: rtl/master_out_port.sv
// master_out_port: serial request transmitter toward slave_in_port (optional REQ timeout via MASTER_OUT_TIMEOUT_EN)
module master_out_port
    import bus_pkg::*;
`ifdef MASTER_OUT_TIMEOUT_EN
#(
    parameter int TIMEOUT = 255
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              burst_en,
    input  logic [BLEN_W-1:0] burst_len,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              slave_ready,
    output logic              master_valid,
    output logic              tx_addr,
    output logic              tx_data,
    output logic [BLEN_W:0]   burst,
    output logic              write_en,
    output logic              read_en,
    output logic              data_req,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [BLEN_W-1:0] blen_q, beat_q;
    logic              rw_q, ben_q;
    logic              hs, accept, active, shifting, last, more, tmo_hit, a_bit, d_bit;

    assign hs       = (state_q == S_REQ) && slave_ready;
    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign active   = state_q inside {S_REQ, S_SHIFT, S_DSHIFT, S_GAP};
    assign shifting = state_q == S_SHIFT || state_q == S_DSHIFT;
    assign last     = (state_q == S_SHIFT  && cnt_q == CNT_W'(ADDR_W - 1))
                   || (state_q == S_DSHIFT && cnt_q == CNT_W'(DATA_W - 1))
                   || (state_q == S_GAP    && cnt_q == CNT_W'(GAP_CYCLES - 1));
    // only write bursts carry further bytes; reads let the slave self-increment
    assign more     = rw_q && ben_q && (beat_q != blen_q);

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;

    // next-state: address goes out only on the first beat, later beats are data only
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:            if (start) state_d = S_REQ;
            S_REQ:             if (hs) state_d = (beat_q == '0) ? S_SHIFT : S_DSHIFT;
                               else if (tmo_hit) state_d = S_DONE;
            S_SHIFT, S_DSHIFT: if (last) state_d = more ? S_GAP : S_DONE;
            S_GAP:             if (last) state_d = S_REQ;
            S_DONE:            state_d = start ? S_REQ : S_IDLE;
            default:           state_d = S_IDLE;
        endcase
    end

    // per-state cycle counter, request capture and beat count
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt_q  <= '0;
            rw_q   <= 1'b0;
            ben_q  <= 1'b0;
            blen_q <= '0;
            beat_q <= '0;
        end else begin
            cnt_q <= (state_d == state_q) ? cnt_q + 1'b1 : '0;
            if (accept) begin
                rw_q   <= rw;
                ben_q  <= burst_en;
                blen_q <= burst_len;
                beat_q <= '0;
            end else if (state_d == S_GAP && state_q != S_GAP) begin
                beat_q <= beat_q + 1'b1;
            end
        end

    piso_shift #(.W(ADDR_W)) u_addr (
        .clk(clk), .reset(reset), .load_i(accept), .shift_i(state_q == S_SHIFT),
        .pdata_i(addr_in), .sout_o(a_bit)
    );

    // next burst byte is taken one cycle after the data_req pulse
    piso_shift #(.W(DATA_W)) u_data (
        .clk(clk), .reset(reset), .load_i(accept || (state_q == S_GAP && cnt_q == CNT_W'(1))),
        .shift_i(shifting), .pdata_i(wdata_in), .sout_o(d_bit)
    );

`ifdef MASTER_OUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    assign tmo_hit     = (state_q == S_REQ) && !slave_ready && tmo_q == TMO_W'(TIMEOUT - 1);
    assign timeout_err = err_q;
    // count unanswered REQ cycles; the error flag holds until the next accepted start
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == S_REQ && !hs) ? tmo_q + 1'b1 : '0;
            err_q <= accept ? 1'b0 : (err_q || tmo_hit);
        end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // outputs decode from state so a reset clears them immediately
    always_comb begin
        master_valid = state_q == S_REQ;
        busy         = active;
        write_en     = active && rw_q;
        read_en      = active && !rw_q;
        burst        = active ? {blen_q, ben_q} : '0;
        done         = state_q == S_DONE;
        data_req     = state_q == S_GAP && cnt_q == '0;
        tx_addr      = state_q == S_SHIFT && a_bit;
        tx_data      = shifting && rw_q && d_bit;
    end
endmodule

// File: tb/tb_master_out_port.sv
// tb_master_out_port: directed table-driven bench for master_out_port (timeout case under MASTER_OUT_TIMEOUT_EN)
module tb_master_out_port;
    logic        clk = 0, reset = 1, start = 0, rw = 0, burst_en = 0, slave_ready = 0;
    logic [11:0] addr_in = 0, burst_len = 0;
    logic [7:0]  wdata_in = 0;
    logic        master_valid, tx_addr, tx_data, write_en, read_en, data_req, busy, done, timeout_err;
    logic [12:0] burst;
    logic [21:0] outs;

    always #5 clk = ~clk;

`ifdef MASTER_OUT_TIMEOUT_EN
    master_out_port #(.TIMEOUT(16)) dut (
`else
    master_out_port dut (
`endif
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr_in(addr_in), .burst_en(burst_en),
        .burst_len(burst_len), .wdata_in(wdata_in), .slave_ready(slave_ready),
        .master_valid(master_valid), .tx_addr(tx_addr), .tx_data(tx_data), .burst(burst),
        .write_en(write_en), .read_en(read_en), .data_req(data_req), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    assign outs = {master_valid, tx_addr, tx_data, burst, write_en, read_en, data_req, busy, done, timeout_err};

`ifdef MASTER_OUT_TIMEOUT_EN
    localparam int STALL = 10;
`else
    localparam int STALL = 20;
`endif

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic        ben;
        logic [11:0] blen;
        logic [23:0] d;
        int          exp_hs;
        int          exp_dreq;
        int          exp_done;
        logic [12:0] exp_burst;
        int          stall;
        logic        poke;
    } vec_t;

    vec_t        vecs[8];
    int          tests = 0, fails = 0;
    int          hs_n, dreq_n, done_off;
    logic [11:0] got_addr;
    logic [11:0] got_data[3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int   bitn = 0, phase = 0, beat = -1, since = -1;
        logic burst_bad = 0, qual_bad = 0, stray = 0, stall_bad = 0;
        hs_n = 0; dreq_n = 0; done_off = -1; got_addr = 0;
        for (int b = 0; b < 3; b++) got_data[b] = 0;
        @(negedge clk);
        rw = v.rw; addr_in = v.addr; burst_en = v.ben; burst_len = v.blen;
        wdata_in = v.d[7:0]; slave_ready = (v.stall == 0); start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 300 && done_off < 0; c++) begin
            slave_ready = (c >= v.stall);
            if (since >= 0) since++;
            if (c < v.stall && (master_valid !== 1'b1 || tx_addr || tx_data || busy !== 1'b1)) stall_bad = 1;
            if (phase > 0) begin
                if (beat == 0) got_addr[bitn] = tx_addr;
                else if (tx_addr) stray = 1;
                if (beat >= 0 && beat < 3) got_data[beat][bitn] = tx_data;
                bitn++; phase--;
            end
            if (busy) begin
                if (burst !== v.exp_burst) burst_bad = 1;
                if (write_en !== v.rw || read_en !== !v.rw) qual_bad = 1;
            end
            if (data_req) begin
                dreq_n++;
                if (dreq_n < 3) wdata_in = v.d[8*dreq_n +: 8];
            end
            if (done) begin
                done_off = since;
                if (busy || write_en || read_en || master_valid || burst != 0) qual_bad = 1;
            end
            if (master_valid && slave_ready) begin
                if (since < 0) since = 0;
                beat = hs_n; hs_n++; bitn = 0;
                phase = (beat == 0) ? 12 : 8;
            end
            if (v.poke && since == 4) begin
                start = 1; rw = 0; addr_in = 12'hFFF;
            end else start = 0;
            @(negedge clk);
        end
        check($sformatf("v%0d_done_off", idx), done_off, v.exp_done);
        check($sformatf("v%0d_addr", idx), got_addr, v.addr);
        for (int b = 0; b < 3; b++)
            check($sformatf("v%0d_data%0d", idx, b), got_data[b],
                  (v.rw && b < v.exp_hs) ? {4'h0, v.d[8*b +: 8]} : 12'h0);
        check($sformatf("v%0d_hs", idx), hs_n, v.exp_hs);
        check($sformatf("v%0d_dreq", idx), dreq_n, v.exp_dreq);
        check($sformatf("v%0d_burst_bad", idx), burst_bad, 0);
        check($sformatf("v%0d_qual_bad", idx), qual_bad, 0);
        check($sformatf("v%0d_stray_addr", idx), stray, 0);
        check($sformatf("v%0d_stall_bad", idx), stall_bad, 0);
        check($sformatf("v%0d_idle_after", idx), {busy, master_valid}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        vecs[0] = '{rw:1, addr:12'h5A3, ben:0, blen:0, d:24'h0000C6, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h000, stall:0, poke:0};
        vecs[1] = '{rw:0, addr:12'h001, ben:0, blen:0, d:24'h000000, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h000, stall:0, poke:0};
        vecs[2] = '{rw:1, addr:12'h010, ben:1, blen:2, d:24'h332211, exp_hs:3, exp_dreq:2, exp_done:47, exp_burst:13'h005, stall:0, poke:0};
        vecs[3] = '{rw:1, addr:12'hFFF, ben:1, blen:0, d:24'h0000A5, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h001, stall:0, poke:0};
        vecs[4] = '{rw:0, addr:12'hABC, ben:1, blen:3, d:24'h000000, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h007, stall:0, poke:0};
        vecs[5] = '{rw:1, addr:12'h800, ben:0, blen:5, d:24'h000001, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h00A, stall:0, poke:0};
        vecs[6] = '{rw:1, addr:12'h123, ben:0, blen:0, d:24'h00005B, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h000, stall:STALL, poke:0};
        vecs[7] = '{rw:1, addr:12'h0F0, ben:0, blen:0, d:24'h00003C, exp_hs:1, exp_dreq:0, exp_done:13, exp_burst:13'h000, stall:0, poke:1};

        repeat (3) @(negedge clk);
        check("reset_outs", outs, 0);
        reset = 0;
        slave_ready = 1;
        repeat (3) @(negedge clk);
        check("idle_ready_high", outs, 0);

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        @(negedge clk);
        rw = 1; addr_in = 12'h5A3; wdata_in = 8'hC6; burst_en = 0; burst_len = 0; slave_ready = 1; start = 1;
        @(negedge clk);
        start = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (master_valid && slave_ready) found = 1;
            else @(negedge clk);
        end
        check("mid_hs_seen", found, 1);
        repeat (6) @(negedge clk);
        check("mid_bit5", tx_addr, 1);
        reset = 1;
        @(posedge clk);
        #1 check("mid_reset_outs", outs, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("post_reset_idle", outs, 0);
        run(vecs[0], 8);

`ifdef MASTER_OUT_TIMEOUT_EN
        begin
            int t_off;
            logic err_at;
            t_off = -1; err_at = 0;
            @(negedge clk);
            rw = 1; addr_in = 12'h777; slave_ready = 0; start = 1;
            @(negedge clk);
            start = 0;
            for (int c = 0; c < 40 && t_off < 0; c++) begin
                if (done) begin t_off = c; err_at = timeout_err; end
                @(negedge clk);
            end
            check("tmo_done_cycle", t_off, 16);
            check("tmo_err_at_done", err_at, 1);
            check("tmo_err_sticky", timeout_err, 1);
            slave_ready = 1; start = 1;
            @(negedge clk);
            start = 0;
            check("tmo_err_cleared", timeout_err, 0);
            found = 0;
            for (int c = 0; c < 40 && !found; c++) begin
                if (done) found = 1;
                @(negedge clk);
            end
            check("tmo_followup_done", found, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
